// File: rtl/idct_block_loader.sv
// Serial-to-parallel coefficient loader for the 8x8 IDCT: ping-pong banks with block resync.
// Build option: define IDCT_LOADER_ZIGZAG_EN to place beats in JPEG zigzag order.
module idct_block_loader #(
  parameter int unsigned WIN = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIN-1:0]    in_data,
  input  logic              in_valid,
  input  logic              in_first,
  output logic              in_ready,
  output logic [64*WIN-1:0] x,
  output logic              x_valid,
  input  logic              x_ready,
  output logic              sync_err
);

  localparam int unsigned NCOEF = 64;
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Beat index to element index within the 8x8 block.
  function automatic logic [5:0] map_idx(input logic [5:0] i);
    map_idx = i;
`ifdef IDCT_LOADER_ZIGZAG_EN
    case (i)
      6'd0:  map_idx = 6'd0;   6'd1:  map_idx = 6'd1;   6'd2:  map_idx = 6'd8;   6'd3:  map_idx = 6'd16;
      6'd4:  map_idx = 6'd9;   6'd5:  map_idx = 6'd2;   6'd6:  map_idx = 6'd3;   6'd7:  map_idx = 6'd10;
      6'd8:  map_idx = 6'd17;  6'd9:  map_idx = 6'd24;  6'd10: map_idx = 6'd32;  6'd11: map_idx = 6'd25;
      6'd12: map_idx = 6'd18;  6'd13: map_idx = 6'd11;  6'd14: map_idx = 6'd4;   6'd15: map_idx = 6'd5;
      6'd16: map_idx = 6'd12;  6'd17: map_idx = 6'd19;  6'd18: map_idx = 6'd26;  6'd19: map_idx = 6'd33;
      6'd20: map_idx = 6'd40;  6'd21: map_idx = 6'd48;  6'd22: map_idx = 6'd41;  6'd23: map_idx = 6'd34;
      6'd24: map_idx = 6'd27;  6'd25: map_idx = 6'd20;  6'd26: map_idx = 6'd13;  6'd27: map_idx = 6'd6;
      6'd28: map_idx = 6'd7;   6'd29: map_idx = 6'd14;  6'd30: map_idx = 6'd21;  6'd31: map_idx = 6'd28;
      6'd32: map_idx = 6'd35;  6'd33: map_idx = 6'd42;  6'd34: map_idx = 6'd49;  6'd35: map_idx = 6'd56;
      6'd36: map_idx = 6'd57;  6'd37: map_idx = 6'd50;  6'd38: map_idx = 6'd43;  6'd39: map_idx = 6'd36;
      6'd40: map_idx = 6'd29;  6'd41: map_idx = 6'd22;  6'd42: map_idx = 6'd15;  6'd43: map_idx = 6'd23;
      6'd44: map_idx = 6'd30;  6'd45: map_idx = 6'd37;  6'd46: map_idx = 6'd44;  6'd47: map_idx = 6'd51;
      6'd48: map_idx = 6'd58;  6'd49: map_idx = 6'd59;  6'd50: map_idx = 6'd52;  6'd51: map_idx = 6'd45;
      6'd52: map_idx = 6'd38;  6'd53: map_idx = 6'd31;  6'd54: map_idx = 6'd39;  6'd55: map_idx = 6'd46;
      6'd56: map_idx = 6'd53;  6'd57: map_idx = 6'd60;  6'd58: map_idx = 6'd61;  6'd59: map_idx = 6'd54;
      6'd60: map_idx = 6'd47;  6'd61: map_idx = 6'd55;  6'd62: map_idx = 6'd62;  6'd63: map_idx = 6'd63;
    endcase
`endif
  endfunction

  logic [0:0]     state, state_nxt;
  logic [5:0]     cnt, cnt_nxt;
  logic           bsel, bsel_nxt;
  logic           x_valid_nxt, sync_err_nxt, in_ready_nxt;
  logic           acc, last, slot_free, swap;
  logic [5:0]     widx;
  logic [WIN-1:0] bank0 [NCOEF];
  logic [WIN-1:0] bank1 [NCOEF];

  assign acc       = in_valid & in_ready;
  assign last      = acc & ~in_first & (cnt == 6'd63);
  assign slot_free = ~x_valid | x_ready;
  assign widx      = map_idx(in_first ? 6'd0 : cnt);

  // A completed block (just finished or parked) moves to the read side once the slot frees.
  assign swap = slot_free & (last | (state == ST_FULL));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bsel_nxt     = bsel ^ swap;
    x_valid_nxt  = swap | (x_valid & ~x_ready);
    sync_err_nxt = acc & in_first & (cnt != 6'd0);
    if (acc) cnt_nxt = in_first ? 6'd1 : cnt + 6'd1;
    case (state)
      ST_FILL: if (last && !slot_free) state_nxt = ST_FULL;
      ST_FULL: if (slot_free) state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
    in_ready_nxt = (state_nxt == ST_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      cnt      <= 6'd0;
      bsel     <= 1'b0;
      x_valid  <= 1'b0;
      sync_err <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bsel     <= bsel_nxt;
      x_valid  <= x_valid_nxt;
      sync_err <= sync_err_nxt;
      in_ready <= in_ready_nxt;
    end
  end

  // Bank bsel is the write bank; the other one drives x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) bank0[i] <= '0;
    end else if (acc && !bsel) begin
      bank0[widx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) bank1[i] <= '0;
    end else if (acc && bsel) begin
      bank1[widx] <= in_data;
    end
  end

  for (genvar k = 0; k < NCOEF; k++) begin : g_x
    assign x[WIN*k +: WIN] = bsel ? bank0[k] : bank1[k];
  end

endmodule

// File: doc/idct_block_loader.md
IDCT_BLOCK_LOADER -- requirements
Module: idct_block_loader

Interface
REQ-001 SHALL have parameter WIN, default 12, coefficient width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_data, input, WIN, one signed coefficient per beat.
REQ-005 SHALL have port in_valid, input, 1, in_data is valid.
REQ-006 SHALL have port in_first, input, 1, beat is coefficient 0 of a new block.
REQ-007 SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both 1.
REQ-008 SHALL have port x, output, 64*WIN, parallel block feeding the IDCT; element k on bits [WIN*k+WIN-1 : WIN*k].
REQ-009 SHALL have port x_valid, output, 1, x holds a complete block.
REQ-010 SHALL have port x_ready, input, 1, downstream takes x when x_valid and x_ready are both 1.
REQ-011 SHALL have port sync_err, output, 1, one-cycle pulse on block resynchronisation.

Function
REQ-012 SHALL hold two 64 x WIN banks: a write bank filled from the input and a read bank driving x.
REQ-013 SHALL keep a 6-bit beat counter cnt; an accepted beat is written to write-bank element map(cnt), then cnt increments and wraps from 63 to 0.
REQ-014 SHALL, on an accepted beat with in_first=1, write to element map(0) and set cnt to 1, discarding any partial block.
REQ-015 SHALL pulse sync_err high for the cycle after an accepted in_first beat that arrives while cnt != 0.
REQ-016 SHALL treat the output slot as free in a cycle when x_valid=0, or when x_valid=1 and x_ready=1.
REQ-017 SHALL, on the edge that accepts beat 63, swap banks if the slot is free that cycle; x_valid is then 1 in the next cycle and input continues into the other bank with no bubble.
REQ-018 SHALL otherwise set wfull=1 and drive in_ready=0 while wfull=1.
REQ-019 SHALL, while wfull=1, swap banks on the first edge on which the slot is free, clearing wfull; in_ready returns to 1 in the next cycle.
REQ-020 SHALL clear x_valid after an x handshake when no swap happens on the same edge.
REQ-021 SHALL hold x constant while x_valid=1 and x_ready=0.
REQ-022 SHALL derive in_ready only from wfull, never combinationally from in_valid or x_ready.
REQ-023 SHALL sustain one beat per cycle when x_ready stays 1, giving one block every 64 cycles.
REQ-024 SHALL have a latency of 1 cycle from acceptance of beat 63 to x_valid=1 when the slot is free.
REQ-025 SHALL ignore in_data, in_first and in_valid when in_ready=0.

Reset
REQ-026 SHALL, while rst=1, immediately force: x_valid=0, in_ready=1, sync_err=0, wfull=0, cnt=0, bank select=0, and every bank element=0, so x=0.
REQ-027 SHALL abandon any partial block when reset is asserted mid-block; the first accepted beat after release is coefficient 0.

Configuration
REQ-028 SHALL, with macro IDCT_LOADER_ZIGZAG_EN defined, use map(i) = the standard JPEG zigzag-to-natural table (0,1,8,16,9,2,3,10,17,24,... ending 62,63).
REQ-029 SHALL, without IDCT_LOADER_ZIGZAG_EN, use map(i)=i (natural raster order).

Verification
REQ-030 SHALL test: without macro, x_ready=1, in_first on beat 0, feed values 0..63 on consecutive cycles -> x_valid=1 in the cycle after beat 63, x element k = k, in_ready stays 1 throughout.
REQ-031 SHALL test: with macro, feed beat i with value i -> x element 8 = 2, element 16 = 3, element 63 = 63, element 1 = 1.
REQ-032 SHALL test: x_ready=0, feed two full blocks -> first block held on x unchanged; in_ready=0 in the cycle after the 128th beat; raising x_ready for one cycle -> second block appears on x next cycle and in_ready=1.
REQ-033 SHALL test: feed 10 beats, then a beat with in_first=1 and value 500 -> sync_err pulses for one cycle; 63 more beats complete the block with element 0 = 500.
REQ-034 SHALL test: assert rst after 30 beats and after x_valid=1 -> x_valid=0 and x=0 without waiting for a clock edge; the next 64 beats form a correct block.
REQ-035 SHALL test: three back-to-back blocks with x_ready=1 -> x_valid pulses exactly every 64 cycles and no beat is lost.
